branch_predictor: RTL

//  IF-stage dynamic branch predictor: a table of 2-bit saturating counters indexed by PC.

---
 rtl/branch_predictor.sv | 105 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: 2-bit saturating counters indexed by PC,
// B-type target generation, IF/ID prediction register and resolution statistics.
module branch_predictor #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [31:0]       fetch_instr,
  output logic              pred_taken_if,
  output logic [ADDR_W-1:0] pred_target_if,
  output logic              branch_taken_id,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispredict_cnt
);

  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
  localparam int unsigned IDX_LSB  = 2;
  localparam int unsigned IDX_MSB  = INDEX_BITS + 1;
  localparam int unsigned IMM_W    = 13;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  logic [1:0]            ctr_q [ENTRIES];
  logic [1:0]            ctr_d [ENTRIES];
  logic                  branch_taken_id_q, branch_taken_id_d;
  logic [31:0]           branch_cnt_q, branch_cnt_d;
  logic [31:0]           mispredict_cnt_q, mispredict_cnt_d;

  logic                  is_branch;
  logic [IMM_W-1:0]      imm13;
  logic [ADDR_W-1:0]     imm;
  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  upd_fire;

  // Bits outside the index window and the non-immediate instruction fields carry no information here.
  logic unused_bits;
  assign unused_bits = ^{upd_pc[ADDR_W-1:IDX_MSB+1], upd_pc[IDX_LSB-1:0], fetch_instr[24:12]};

  assign fetch_idx = fetch_pc[IDX_MSB:IDX_LSB];
  assign upd_idx   = upd_pc[IDX_MSB:IDX_LSB];
  assign upd_fire  = upd_valid & enable;

  // B-type decode, target adder (wraps modulo 2^ADDR_W) and zero-latency prediction.
  always_comb begin
    is_branch      = (fetch_instr[6:0] == OP_BRANCH);
    imm13          = {fetch_instr[31], fetch_instr[7], fetch_instr[30:25], fetch_instr[11:8], 1'b0};
    imm            = {{(ADDR_W-IMM_W){imm13[IMM_W-1]}}, imm13};
    pred_target_if = fetch_pc + imm;
    pred_taken_if  = is_branch & ctr_q[fetch_idx][1];
  end

  // Next state: counter training, IF/ID prediction copy and saturating statistics.
  always_comb begin
    ctr_d             = ctr_q;
    branch_taken_id_d = branch_taken_id_q;
    branch_cnt_d      = branch_cnt_q;
    mispredict_cnt_d  = mispredict_cnt_q;

    if (enable) begin
      branch_taken_id_d = flush ? 1'b0 : pred_taken_if;
    end

    if (upd_fire) begin
      if (upd_taken) begin
        if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'(1);
      end else begin
        if (ctr_q[upd_idx] != 2'b00) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'(1);
      end
      if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + 32'(1);
      if ((upd_taken != upd_pred) && (mispredict_cnt_q != CNT_MAX)) begin
        mispredict_cnt_d = mispredict_cnt_q + 32'(1);
      end
    end
  end

  // State registers; reset discards all training immediately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= INIT_STATE;
      branch_taken_id_q <= 1'b0;
      branch_cnt_q      <= 32'd0;
      mispredict_cnt_q  <= 32'd0;
    end else begin
      ctr_q             <= ctr_d;
      branch_taken_id_q <= branch_taken_id_d;
      branch_cnt_q      <= branch_cnt_d;
      mispredict_cnt_q  <= mispredict_cnt_d;
    end
  end

  assign branch_taken_id = branch_taken_id_q;
  assign branch_cnt      = branch_cnt_q;
  assign mispredict_cnt  = mispredict_cnt_q;

endmodule
